// File: rtl/nkmd_dai_i2s_link.sv
`default_nettype none
// ============================================================================
//  Module      : nkmd_dai_i2s_link
//  Description : dmix-side DAI link. Drains the TX ringbuffer onto an I2S
//                master output and pushes deserialized I2S input words into
//                the RX ringbuffer. Stereo is interleaved left, then right.
//  Revision    : 1.0 - initial release
// ============================================================================
module nkmd_dai_i2s_link #(
    parameter int BCK_DIV  = 4,
    parameter int SAMPLE_W = 24,
    parameter int SLOT_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable_i,
    output logic                tx_pop_o,
    input  logic [SAMPLE_W-1:0] tx_data_i,
    input  logic                tx_ack_i,
    output logic [SAMPLE_W-1:0] rx_data_o,
    output logic                rx_ack_o,
    output logic                i2s_bck_o,
    output logic                i2s_lrck_o,
    output logic                i2s_dout_o,
    input  logic                i2s_din_i,
    output logic                underrun_o
);

    localparam int c_DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam int c_CNT_W = $clog2(2 * SLOT_W);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST    = c_DIV_W'(BCK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_FRAME_LAST  = c_CNT_W'(2 * SLOT_W - 1);
    localparam logic [c_CNT_W-1:0] c_SLOT        = c_CNT_W'(SLOT_W);
    localparam logic [c_CNT_W-1:0] c_SLOT_LAST   = c_CNT_W'(SLOT_W - 1);
    localparam logic [c_CNT_W-1:0] c_SAMPLE_LAST = c_CNT_W'(SAMPLE_W);

    logic [c_DIV_W-1:0]  r_div;
    logic                r_bck;
    logic [c_CNT_W-1:0]  r_bitcnt;
    logic                r_run;
    logic                r_tx_pop;
    logic                r_pop_d;
    logic [SAMPLE_W-1:0] r_hold;
    logic                r_hold_valid;
    logic [SAMPLE_W-1:0] r_tx_shift;
    logic                r_underrun;
    logic [SAMPLE_W-2:0] r_rx_shift;
    logic [SAMPLE_W-1:0] r_rx_data;
    logic                r_rx_ack;

    logic                w_wrap;
    logic                w_rise;
    logic                w_fall;
    logic                w_lrck;
    logic [c_CNT_W-1:0]  w_slot_bit;
    logic [c_CNT_W-1:0]  w_bitcnt_nxt;
    logic                w_in_sample;
    logic [SAMPLE_W-1:0] w_rx_word;

    assign w_wrap       = (r_div == c_DIV_LAST);
    assign w_rise       = w_wrap & ~r_bck;
    assign w_fall       = w_wrap & r_bck;
    assign w_lrck       = (r_bitcnt >= c_SLOT);
    assign w_slot_bit   = w_lrck ? (r_bitcnt - c_SLOT) : r_bitcnt;
    assign w_bitcnt_nxt = (r_bitcnt == c_FRAME_LAST) ? '0 : (r_bitcnt + c_CNT_W'(1));
    // Data bits occupy slot bits 1..SAMPLE_W: one bck of delay after the lrck edge.
    assign w_in_sample  = (w_slot_bit != '0) && (w_slot_bit <= c_SAMPLE_LAST);
    assign w_rx_word    = {r_rx_shift, i2s_din_i};

    always_ff @(posedge clk) begin
        if (!rst || !enable_i) begin
            r_div        <= '0;
            r_bck        <= 1'b0;
            r_bitcnt     <= '0;
            r_run        <= 1'b0;
            r_tx_pop     <= 1'b0;
            r_pop_d      <= 1'b0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_tx_shift   <= '0;
            r_underrun   <= 1'b0;
            r_rx_shift   <= '0;
            r_rx_data    <= '0;
            r_rx_ack     <= 1'b0;
        end else begin
            r_run      <= 1'b1;
            r_div      <= w_wrap ? '0 : (r_div + c_DIV_W'(1));
            r_underrun <= 1'b0;
            r_rx_ack   <= 1'b0;
            if (w_wrap) begin
                r_bck <= ~r_bck;
            end

            // First clk after idle fetches the first left sample; afterwards
            // one pop per slot, issued as the slot begins.
            r_tx_pop <= ~r_run | (w_fall & (w_slot_bit == c_SLOT_LAST));
            r_pop_d  <= r_tx_pop;

            if (w_fall) begin
                r_bitcnt <= w_bitcnt_nxt;
                if (w_slot_bit == '0) begin
                    r_tx_shift   <= r_hold_valid ? r_hold : '0;
                    r_hold_valid <= 1'b0;
                    r_underrun   <= ~r_hold_valid;
                end else if (w_in_sample) begin
                    r_tx_shift <= {r_tx_shift[SAMPLE_W-2:0], 1'b0};
                end
            end

            // Only an ack answering the pop of the previous clk is accepted.
            if (tx_ack_i && r_pop_d) begin
                r_hold       <= tx_data_i;
                r_hold_valid <= 1'b1;
            end

            if (w_rise && w_in_sample) begin
                r_rx_shift <= w_rx_word[SAMPLE_W-2:0];
                if (w_slot_bit == c_SAMPLE_LAST) begin
                    r_rx_data <= w_rx_word;
                    r_rx_ack  <= 1'b1;
                end
            end
        end
    end

    assign tx_pop_o   = r_tx_pop;
    assign rx_data_o  = r_rx_data;
    assign rx_ack_o   = r_rx_ack;
    assign i2s_bck_o  = r_bck;
    assign i2s_lrck_o = w_lrck;
    assign i2s_dout_o = w_in_sample ? r_tx_shift[SAMPLE_W-1] : 1'b0;
    assign underrun_o = r_underrun;

endmodule
`default_nettype wire

// File: doc/nkmd_dai_i2s_link.md
Name: nkmd_dai_i2s_link

Overview:
- dmix-side end of the DAI sample streams: drains samples from the nkmd TX ringbuffer via the pop/ack handshake and serializes them onto an I2S master output.
- Deserializes the I2S input and pushes each received word into the nkmd RX ringbuffer via a data/ack strobe.
- Stereo is interleaved on the single stream: left word first, then right.

Parameters:
- BCK_DIV, 4: clk cycles per half bck period. Must be >= 2.
- SAMPLE_W, 24: sample width in bits.
- SLOT_W, 32: bck periods per channel slot; frame = 2*SLOT_W bits. Must be >= SAMPLE_W+2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (block in reset while rst==0)
- enable_i  in  1  run; low holds the link idle
- tx_pop_o  out  1  one-clk request for the next TX sample
- tx_data_i  in  SAMPLE_W  TX sample, captured when tx_ack_i==1
- tx_ack_i  in  1  TX sample valid (arrives the clk after tx_pop_o)
- rx_data_o  out  SAMPLE_W  received sample, valid while rx_ack_o==1
- rx_ack_o  out  1  one-clk strobe: push rx_data_o
- i2s_bck_o  out  1  bit clock
- i2s_lrck_o  out  1  0=left slot, 1=right slot
- i2s_dout_o  out  1  serial data out
- i2s_din_i  in  1  serial data in
- underrun_o  out  1  one-clk pulse: slot loaded without a fresh TX sample

Behaviour:
- Reset / idle (rst==0, or enable_i==0):
  - bck=0, lrck=0, dout=0; tx_pop_o=0, rx_ack_o=0, underrun_o=0, rx_data_o=0.
  - Divider cleared, bit counter bitcnt=0, holding/shift registers cleared, holding-valid flag cleared.
  - enable_i falling mid-frame takes effect on the next clk with the same values; the partial RX word is discarded.
- Divider:
  - div counts 0..BCK_DIV-1; on wrap, bck toggles.
  - bck 0->1 is a "rise" tick; bck 1->0 is a "fall" tick.
  - One bit period = 2*BCK_DIV clk; one frame = 2*SLOT_W*2*BCK_DIV clk (512 at defaults).
- Bit counter:
  - bitcnt runs 0..2*SLOT_W-1 and advances on each fall tick, wrapping to 0.
  - lrck = (bitcnt >= SLOT_W), updated with bitcnt.
  - slot bit s = bitcnt mod SLOT_W.
- TX fetch:
  - tx_pop_o pulses for one clk on the fall tick that enters s=0.
  - It also pulses on the first clk with enable_i high after idle, to fetch the first left sample.
  - When tx_ack_i==1, tx_data_i is captured into the holding register and holding-valid is set. Ack without a preceding pop is ignored.
- TX shift:
  - On the fall tick entering s=1, the shift register loads the holding register and holding-valid clears.
  - If holding-valid==0 at that tick, the shift register loads 0 and underrun_o pulses that clk.
  - dout = shift MSB during s=1..SAMPLE_W, shifting left on each fall tick; dout=0 for s=0 and s>SAMPLE_W. This gives I2S one-bit delay after the lrck edge, MSB first.
- RX:
  - On rise ticks with s in 1..SAMPLE_W, i2s_din_i is shifted into the RX shift register LSB.
  - On the rise tick of s=SAMPLE_W, the completed word is copied to rx_data_o, and rx_ack_o is high for exactly the next clk.
  - rx_data_o holds its value until the next word.
  - The first RX word after enable is the left slot of the first frame.
- Simultaneous events:
  - A pop, an ack and a shift load never coincide, because BCK_DIV>=2 separates them.
  - rx_ack_o is independent of TX activity.
- Counts: exactly one pop and one rx_ack per slot; no backpressure on either stream.

Test Plan:
- Reset, default params: rst=0 for 5 clk, enable_i=1 -> all outputs 0 during reset; first tx_pop_o on the first clk after rst=1; bck period 8 clk; lrck toggles every 256 clk.
- TX path: ack samples 0xABCDEF, 0x123456 -> dout during left s=1..24 carries 0xABCDEF MSB-first (bit changes on bck fall), right carries 0x123456; dout=0 at s=0 and s=25..31.
- RX path: din driven with 0x800001 in left and 0x7FFFFF in right, changing on bck fall -> rx_ack_o pulses once per slot, 1 clk wide, rx_data_o=0x800001 then 0x7FFFFF.
- Underrun: withhold tx_ack_i for one slot -> underrun_o pulses once at s=1, that slot's dout is all zero, next slot is normal.
- Loopback: dout tied to din, ramp 1..16 fed through tx -> rx_data_o sequence 1..16 in order, no missed or duplicate acks.
- Disable mid-frame at bitcnt=40, re-enable after 100 clk -> bck/lrck/dout=0 while disabled, no rx_ack for the partial word; restart at the left slot with a fresh pop.
